// File: rtl/pipe_defs.sv
`default_nettype none
// ============================================================================
// Package     : pipe_defs
// Description : Shared constants and types for the destination/forwarding
//               pipeline: forwarding-select codes, register-address width,
//               the hard-wired zero register and the pipeline entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_defs;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [1:0] fwd_sel_t;

    // One in-flight destination record carried down the pipe
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_to_reg;
    } pipe_entry_t;

    // Build an entry for capture; register $0 is never a real write target
    function automatic pipe_entry_t make_entry(
        input logic [REG_ADDR_W-1:0] dest,
        input logic                  reg_write,
        input logic                  mem_to_reg
    );
        pipe_entry_t e;
        e.dest       = dest;
        e.reg_write  = reg_write && (dest != ZERO_REG);
        e.mem_to_reg = mem_to_reg;
        return e;
    endfunction

endpackage : pipe_defs
`default_nettype wire

// File: rtl/fwd_cmp.sv
`default_nettype none
// ============================================================================
// Module      : fwd_cmp
// Description : Priority forwarding compare for one source operand. The MEM
//               stage (newest producer) wins over WB; source $0 never
//               forwards. Compare logic exists only when DEST_FWD_EN is
//               defined, otherwise the select is tied to FWD_NONE.
// Macro       : DEST_FWD_EN
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_cmp
    import pipe_defs::*;
(
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic [REG_ADDR_W-1:0] dest_mem_i,
    input  logic                  reg_write_mem_i,
    input  logic [REG_ADDR_W-1:0] dest_wb_i,
    input  logic                  reg_write_wb_i,
    output fwd_sel_t              fwd_o
);

`ifdef DEST_FWD_EN
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = reg_write_mem_i && (dest_mem_i == src_i) && (dest_mem_i != ZERO_REG);
    assign w_wb_hit  = reg_write_wb_i  && (dest_wb_i  == src_i) && (dest_wb_i  != ZERO_REG);

    // Newest producer first: MEM, then WB, otherwise read the register file
    always_comb begin
        fwd_o = FWD_NONE;
        if (w_mem_hit) begin
            fwd_o = FWD_MEM;
        end else if (w_wb_hit) begin
            fwd_o = FWD_WB;
        end
    end
`else
    logic unused_cmp_inputs;

    assign unused_cmp_inputs = ^{src_i, dest_mem_i, reg_write_mem_i, dest_wb_i, reg_write_wb_i};
    assign fwd_o             = FWD_NONE;
`endif

endmodule : fwd_cmp
`default_nettype wire

// File: rtl/dest_fwd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dest_fwd_pipe
// Description : Two-entry destination pipeline (EX/MEM, MEM/WB) carrying the
//               write destination, write enable and load flag, plus operand
//               forwarding selects for rs/rt. Flush bubbles EX/MEM and has
//               priority over stall; stall holds both entries.
// Macro       : DEST_FWD_EN - when defined, forwarding compares are built;
//               when undefined, fwd_a/fwd_b are tied to 2'b00.
// Revision    : 1.0 - initial release
// ============================================================================
module dest_fwd_pipe
    import pipe_defs::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] dest_ex,
    input  logic                  reg_write_ex,
    input  logic                  mem_to_reg_ex,
    input  logic [REG_ADDR_W-1:0] rs_ex,
    input  logic [REG_ADDR_W-1:0] rt_ex,
    output logic [REG_ADDR_W-1:0] dest_mem,
    output logic [REG_ADDR_W-1:0] dest_wb,
    output logic                  reg_write_mem,
    output logic                  reg_write_wb,
    output logic                  mem_to_reg_mem,
    output logic                  mem_to_reg_wb,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    pipe_entry_t ex_mem_q, ex_mem_d;
    pipe_entry_t mem_wb_q, mem_wb_d;

    // Next-state: flush bubbles EX/MEM while WB still advances; stall holds all
    always_comb begin
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        if (flush) begin
            ex_mem_d = '0;
            mem_wb_d = ex_mem_q;
        end else if (!stall) begin
            ex_mem_d = make_entry(dest_ex, reg_write_ex, mem_to_reg_ex);
            mem_wb_d = ex_mem_q;
        end
    end

    // Pipeline registers; reset discards both in-flight entries immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign dest_mem       = ex_mem_q.dest;
    assign reg_write_mem  = ex_mem_q.reg_write;
    assign mem_to_reg_mem = ex_mem_q.mem_to_reg;
    assign dest_wb        = mem_wb_q.dest;
    assign reg_write_wb   = mem_wb_q.reg_write;
    assign mem_to_reg_wb  = mem_wb_q.mem_to_reg;

    fwd_cmp u_fwd_rs (
        .src_i           (rs_ex),
        .dest_mem_i      (ex_mem_q.dest),
        .reg_write_mem_i (ex_mem_q.reg_write),
        .dest_wb_i       (mem_wb_q.dest),
        .reg_write_wb_i  (mem_wb_q.reg_write),
        .fwd_o           (fwd_a)
    );

    fwd_cmp u_fwd_rt (
        .src_i           (rt_ex),
        .dest_mem_i      (ex_mem_q.dest),
        .reg_write_mem_i (ex_mem_q.reg_write),
        .dest_wb_i       (mem_wb_q.dest),
        .reg_write_wb_i  (mem_wb_q.reg_write),
        .fwd_o           (fwd_b)
    );

endmodule : dest_fwd_pipe
`default_nettype wire

// File: tb/tb_dest_fwd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dest_fwd_pipe
// Description : Self-checking bench for dest_fwd_pipe: directed vector table,
//               async-reset sequence, then randomized traffic against an
//               in-flight-queue reference model. Expected forwarding follows
//               the DEST_FWD_EN build setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dest_fwd_pipe;

`ifdef DEST_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       stall, flush;
    logic [4:0] dest_ex, rs_ex, rt_ex;
    logic       reg_write_ex, mem_to_reg_ex;
    logic [4:0] dest_mem, dest_wb;
    logic       reg_write_mem, reg_write_wb, mem_to_reg_mem, mem_to_reg_wb;
    logic [1:0] fwd_a, fwd_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dest_fwd_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .dest_ex        (dest_ex),
        .reg_write_ex   (reg_write_ex),
        .mem_to_reg_ex  (mem_to_reg_ex),
        .rs_ex          (rs_ex),
        .rt_ex          (rt_ex),
        .dest_mem       (dest_mem),
        .dest_wb        (dest_wb),
        .reg_write_mem  (reg_write_mem),
        .reg_write_wb   (reg_write_wb),
        .mem_to_reg_mem (mem_to_reg_mem),
        .mem_to_reg_wb  (mem_to_reg_wb),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against an expected set
    task automatic check_all(input string tag,
                             input logic [4:0] e_dm, input logic e_rwm, input logic e_m2rm,
                             input logic [4:0] e_dw, input logic e_rww, input logic e_m2rw,
                             input logic [1:0] e_fa, input logic [1:0] e_fb);
        check({tag, ".dest_mem"},       8'(dest_mem),       8'(e_dm));
        check({tag, ".reg_write_mem"},  8'(reg_write_mem),  8'(e_rwm));
        check({tag, ".mem_to_reg_mem"}, 8'(mem_to_reg_mem), 8'(e_m2rm));
        check({tag, ".dest_wb"},        8'(dest_wb),        8'(e_dw));
        check({tag, ".reg_write_wb"},   8'(reg_write_wb),   8'(e_rww));
        check({tag, ".mem_to_reg_wb"},  8'(mem_to_reg_wb),  8'(e_m2rw));
        check({tag, ".fwd_a"},          8'(fwd_a),          8'(e_fa));
        check({tag, ".fwd_b"},          8'(fwd_b),          8'(e_fb));
    endtask

    function automatic logic [1:0] gate(input logic [1:0] f);
        return FWD_ON ? f : 2'b00;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       stall, flush;
        logic [4:0] dest;
        logic       rw, m2r;
        logic [4:0] rs, rt;
        logic [4:0] e_dm;  logic e_rwm; logic e_m2rm;
        logic [4:0] e_dw;  logic e_rww; logic e_m2rw;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t vecs [11];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0] dest;
        logic       rw;
        logic       m2r;
    } ent_t;

    ent_t inflight [2];   // [0] = younger (MEM), [1] = older (WB)

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (!FWD_ON || src == 5'd0) return 2'b00;
        for (int age = 0; age < 2; age++) begin
            if (inflight[age].rw && inflight[age].dest == src)
                return (age == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic model_edge();
        if (flush) begin
            inflight[1] = inflight[0];
            inflight[0] = '0;
        end else if (!stall) begin
            inflight[1] = inflight[0];
            inflight[0] = '{dest: dest_ex, rw: reg_write_ex && (dest_ex != 5'd0), m2r: mem_to_reg_ex};
        end
    endtask

    task automatic model_check(input string tag);
        check_all(tag,
                  inflight[0].dest, inflight[0].rw, inflight[0].m2r,
                  inflight[1].dest, inflight[1].rw, inflight[1].m2r,
                  model_fwd(rs_ex), model_fwd(rt_ex));
    endtask

    initial begin
        //        stl flu dst rw m2r rs  rt   dm rwm m2m dw rww m2w fa     fb
        vecs[0]  = '{0, 0, 8,  1, 0, 8,  0,   8, 1, 0,  0, 0, 0,  2'b10, 2'b00};
        vecs[1]  = '{0, 0, 3,  0, 1, 8,  3,   3, 0, 1,  8, 1, 0,  2'b01, 2'b00};
        vecs[2]  = '{0, 0, 9,  1, 0, 3,  9,   9, 1, 0,  3, 0, 1,  2'b00, 2'b10};
        vecs[3]  = '{0, 0, 9,  1, 1, 0,  9,   9, 1, 1,  9, 1, 0,  2'b00, 2'b10};
        vecs[4]  = '{0, 0, 0,  1, 0, 0,  9,   0, 0, 0,  9, 1, 1,  2'b00, 2'b01};
        vecs[5]  = '{0, 0, 5,  1, 0, 5,  0,   5, 1, 0,  0, 0, 0,  2'b10, 2'b00};
        vecs[6]  = '{1, 0, 7,  1, 0, 5,  0,   5, 1, 0,  0, 0, 0,  2'b10, 2'b00};
        vecs[7]  = '{1, 0, 7,  1, 0, 5,  0,   5, 1, 0,  0, 0, 0,  2'b10, 2'b00};
        vecs[8]  = '{1, 1, 7,  1, 0, 5,  0,   0, 0, 0,  5, 1, 0,  2'b01, 2'b00};
        vecs[9]  = '{0, 1, 12, 1, 0, 5,  0,   0, 0, 0,  0, 0, 0,  2'b00, 2'b00};
        vecs[10] = '{0, 0, 12, 1, 1, 12, 0,  12, 1, 1,  0, 0, 0,  2'b10, 2'b00};

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        dest_ex = 5'd0; reg_write_ex = 1'b0; mem_to_reg_ex = 1'b0;
        rs_ex = 5'd0; rt_ex = 5'd0;

        // Reset state, with a live-looking source request and inputs
        repeat (2) @(posedge clk);
        rs_ex = 5'd8; rt_ex = 5'd8; dest_ex = 5'd8; reg_write_ex = 1'b1;
        @(posedge clk); #1;
        check_all("reset", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Table: inputs set at negedge, captured on posedge, checked #1 later
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i != 0) @(negedge clk);
            stall = vecs[i].stall; flush = vecs[i].flush;
            dest_ex = vecs[i].dest; reg_write_ex = vecs[i].rw; mem_to_reg_ex = vecs[i].m2r;
            rs_ex = vecs[i].rs; rt_ex = vecs[i].rt;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i),
                      vecs[i].e_dm, vecs[i].e_rwm, vecs[i].e_m2rm,
                      vecs[i].e_dw, vecs[i].e_rww, vecs[i].e_m2rw,
                      gate(vecs[i].e_fa), gate(vecs[i].e_fb));
        end

        // Async reset between edges while dest_mem holds 12
        stall = 1'b0; flush = 1'b0;
        #2;
        check("pre_rst.dest_mem", 8'(dest_mem), 8'd12);
        rst = 1'b1;
        #1;
        check_all("async_rst", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Held through an edge: nothing captured while rst is high
        dest_ex = 5'd6; reg_write_ex = 1'b1; rs_ex = 5'd6;
        @(posedge clk); #1;
        check_all("rst_hold", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);

        // First capture on the first edge with rst low
        @(negedge clk);
        rst = 1'b0; dest_ex = 5'd4; reg_write_ex = 1'b1; mem_to_reg_ex = 1'b0; rs_ex = 5'd4;
        @(posedge clk); #1;
        check_all("post_rst", 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, gate(2'b10), 2'b00);

        // Randomized traffic against the reference model
        inflight[0] = '{dest: 5'd4, rw: 1'b1, m2r: 1'b0};
        inflight[1] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            rst           = 1'b0;
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            dest_ex       = 5'($urandom_range(0, 7));
            reg_write_ex  = 1'($urandom);
            mem_to_reg_ex = 1'($urandom);
            rs_ex         = 5'($urandom_range(0, 7));
            rt_ex         = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                inflight[0] = '0;
                inflight[1] = '0;
                #1;
                model_check($sformatf("rnd_rst%0d", cyc));
                @(posedge clk); #1;
                model_check($sformatf("rnd_rsth%0d", cyc));
            end else begin
                @(posedge clk);
                model_edge();
                #1;
                model_check($sformatf("rnd%0d", cyc));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dest_fwd_pipe
`default_nettype wire
